// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: pipeline encodings shared by decode, ID/EX and the ALU controller
package id_ex_stage_reg_pkg;
   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;
   localparam logic [3:0] ALUOP_ADD   = 4'd0;
   localparam logic [3:0] ALUOP_SUB   = 4'd1;
   localparam logic [3:0] ALUOP_RTYPE = 4'd2;
   localparam logic [3:0] ALUOP_AND   = 4'd3;
   localparam logic [3:0] ALUOP_OR    = 4'd4;
   localparam logic [3:0] ALUOP_SLT   = 4'd5;
   localparam logic [3:0] ALUOP_LUI   = 4'd6;
endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// id_ex_stage_reg_load_use_detect: flags a load in ID/EX whose target the ID instruction reads
module id_ex_stage_reg_load_use_detect #(
   parameter int REG_AW = 5
) (
   input  logic              valid,
   input  logic              memread,
   input  logic [REG_AW-1:0] rt_ex,
   input  logic [REG_AW-1:0] rs_id,
   input  logic [REG_AW-1:0] rt_id,
   input  logic              uses_rt,
   output logic              haz
);
   assign haz = valid & memread & (|rt_ex) & ((rt_ex == rs_id) | (uses_rt & (rt_ex == rt_id)));
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion and bubble counter
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] reg_data1_in,
   input  logic [DATA_W-1:0] reg_data2_in,
   input  logic [DATA_W-1:0] sign_ext_offset_in,
   input  logic [DATA_W-1:0] pc_plus4_in,
   input  logic [REG_AW-1:0] rs_in,
   input  logic [REG_AW-1:0] rt_in,
   input  logic [REG_AW-1:0] rd_in,
   input  logic [5:0]        funct_in,
   input  logic [4:0]        shamt_in,
   input  logic              alusrc_in,
   input  logic [1:0]        regdst_in,
   input  logic [3:0]        aluop_in,
   input  logic              memread_in,
   input  logic              memwrite_in,
   input  logic              regwrite_in,
   input  logic              memtoreg_in,
   input  logic              uses_rt_in,
   input  logic              flush,
   input  logic              hold,
   output logic [DATA_W-1:0] reg_data1_out,
   output logic [DATA_W-1:0] reg_data2_out,
   output logic [DATA_W-1:0] sign_ext_offset_out,
   output logic [DATA_W-1:0] pc_plus4_out,
   output logic [REG_AW-1:0] rs_out,
   output logic [REG_AW-1:0] rt_out,
   output logic [REG_AW-1:0] rd_out,
   output logic [5:0]        funct_out,
   output logic [4:0]        shamt_out,
   output logic              alusrc_out,
   output logic [1:0]        regdst_out,
   output logic [3:0]        aluop_out,
   output logic              memread_out,
   output logic              memwrite_out,
   output logic              regwrite_out,
   output logic              memtoreg_out,
   output logic              valid_out,
   output logic              stall_out,
   output logic [CNT_W-1:0]  bubble_count
);
   logic haz, kill, rst_q;
   id_ex_stage_reg_load_use_detect #(.REG_AW(REG_AW)) u_detect (
      .valid   (valid_out),
      .memread (memread_out),
      .rt_ex   (rt_out),
      .rs_id   (rs_in),
      .rt_id   (rt_in),
      .uses_rt (uses_rt_in),
      .haz     (haz)
   );
   assign kill = flush | haz;
   // rst_q keeps stall low for the first cycle after reset releases
   assign stall_out = ~Reset & ~rst_q & (hold | (haz & ~flush));
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rst_q               <= 1'b1;
         reg_data1_out       <= '0;
         reg_data2_out       <= '0;
         sign_ext_offset_out <= '0;
         pc_plus4_out        <= '0;
         rs_out              <= '0;
         rt_out              <= '0;
         rd_out              <= '0;
         funct_out           <= '0;
         shamt_out           <= '0;
         alusrc_out          <= 1'b0;
         regdst_out          <= REGDST_RT;
         aluop_out           <= ALUOP_ADD;
         memread_out         <= 1'b0;
         memwrite_out        <= 1'b0;
         regwrite_out        <= 1'b0;
         memtoreg_out        <= 1'b0;
         valid_out           <= 1'b0;
         bubble_count        <= '0;
      end else begin
         rst_q <= 1'b0;
         if (!hold) begin
            reg_data1_out       <= kill ? '0 : reg_data1_in;
            reg_data2_out       <= kill ? '0 : reg_data2_in;
            sign_ext_offset_out <= kill ? '0 : sign_ext_offset_in;
            pc_plus4_out        <= kill ? '0 : pc_plus4_in;
            rs_out              <= kill ? '0 : rs_in;
            rt_out              <= kill ? '0 : rt_in;
            rd_out              <= kill ? '0 : rd_in;
            funct_out           <= kill ? '0 : funct_in;
            shamt_out           <= kill ? '0 : shamt_in;
            alusrc_out          <= ~kill & alusrc_in;
            regdst_out          <= kill ? REGDST_RT : regdst_in;
            aluop_out           <= kill ? ALUOP_ADD : aluop_in;
            memread_out         <= ~kill & memread_in;
            memwrite_out        <= ~kill & memwrite_in;
            regwrite_out        <= ~kill & regwrite_in;
            memtoreg_out        <= ~kill & memtoreg_in;
            valid_out           <= ~kill;
            if (haz && !flush && !(&bubble_count)) bubble_count <= bubble_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_id_ex_stage_reg;
   typedef struct {
      logic        rst, hold, flush;
      logic [31:0] d1;
      logic [4:0]  rs, rt, rd;
      logic        mr, rw, urt;
      logic        e_stall, chk, e_valid;
      logic [31:0] e_d1;
      logic [4:0]  e_rs, e_rt, e_rd;
      logic        e_rw, e_mr;
      logic [3:0]  e_cnt;
   } vec_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] reg_data1_in = '0, reg_data2_in = '0, sign_ext_offset_in = '0, pc_plus4_in = '0;
   logic [4:0]  rs_in = '0, rt_in = '0, rd_in = '0, shamt_in = '0;
   logic [5:0]  funct_in = '0;
   logic        alusrc_in = 1'b0, memread_in = 1'b0, memwrite_in = 1'b0, regwrite_in = 1'b0;
   logic        memtoreg_in = 1'b0, uses_rt_in = 1'b0, flush = 1'b0, hold = 1'b0;
   logic [1:0]  regdst_in = '0;
   logic [3:0]  aluop_in = '0;
   logic [31:0] reg_data1_out, reg_data2_out, sign_ext_offset_out, pc_plus4_out;
   logic [4:0]  rs_out, rt_out, rd_out, shamt_out;
   logic [5:0]  funct_out;
   logic        alusrc_out, memread_out, memwrite_out, regwrite_out, memtoreg_out;
   logic        valid_out, stall_out;
   logic [1:0]  regdst_out;
   logic [3:0]  aluop_out;
   logic [3:0]  bubble_count;

   int compared = 0;
   int mismatched = 0;
   vec_t q[$];

   always #5 Clk = ~Clk;

   id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .reg_data1_in(reg_data1_in), .reg_data2_in(reg_data2_in),
      .sign_ext_offset_in(sign_ext_offset_in), .pc_plus4_in(pc_plus4_in),
      .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .funct_in(funct_in), .shamt_in(shamt_in),
      .alusrc_in(alusrc_in), .regdst_in(regdst_in), .aluop_in(aluop_in),
      .memread_in(memread_in), .memwrite_in(memwrite_in), .regwrite_in(regwrite_in),
      .memtoreg_in(memtoreg_in), .uses_rt_in(uses_rt_in), .flush(flush), .hold(hold),
      .reg_data1_out(reg_data1_out), .reg_data2_out(reg_data2_out),
      .sign_ext_offset_out(sign_ext_offset_out), .pc_plus4_out(pc_plus4_out),
      .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .funct_out(funct_out), .shamt_out(shamt_out),
      .alusrc_out(alusrc_out), .regdst_out(regdst_out), .aluop_out(aluop_out),
      .memread_out(memread_out), .memwrite_out(memwrite_out), .regwrite_out(regwrite_out),
      .memtoreg_out(memtoreg_out), .valid_out(valid_out), .stall_out(stall_out),
      .bubble_count(bubble_count)
   );

   function automatic vec_t mk(input logic rst, hold_v, flush_v, logic [31:0] d1, logic [4:0] rs, rt, rd,
                               logic mr, rw, urt, e_stall, chk, e_valid, logic [31:0] e_d1,
                               logic [4:0] e_rs, e_rt, e_rd, logic e_rw, e_mr, logic [3:0] e_cnt);
      vec_t v;
      v.rst = rst; v.hold = hold_v; v.flush = flush_v; v.d1 = d1;
      v.rs = rs; v.rt = rt; v.rd = rd; v.mr = mr; v.rw = rw; v.urt = urt;
      v.e_stall = e_stall; v.chk = chk; v.e_valid = e_valid; v.e_d1 = e_d1;
      v.e_rs = e_rs; v.e_rt = e_rt; v.e_rd = e_rd; v.e_rw = e_rw; v.e_mr = e_mr; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s got=%0h exp=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Secondary fields are driven as fixed functions of reg_data1_in so they can be checked too
   task automatic drive(input vec_t v);
      @(posedge Clk);
      #2;
      Reset = v.rst; hold = v.hold; flush = v.flush;
      reg_data1_in = v.d1; reg_data2_in = ~v.d1; sign_ext_offset_in = v.d1 << 1;
      pc_plus4_in = v.d1 + 32'd4; funct_in = v.d1[5:0]; shamt_in = v.d1[10:6];
      alusrc_in = v.d1[0]; regdst_in = v.d1[2:1]; aluop_in = v.d1[6:3];
      memwrite_in = v.d1[7]; memtoreg_in = v.d1[8];
      rs_in = v.rs; rt_in = v.rt; rd_in = v.rd;
      memread_in = v.mr; regwrite_in = v.rw; uses_rt_in = v.urt;
      q.push_back(v);
   endtask

   initial begin
      vec_t v;
      logic [31:0] e;
      forever begin
         @(negedge Clk);
         if (q.size() > 0) begin
            v = q.pop_front();
            chk("stall", 32'(stall_out), 32'(v.e_stall));
            if (v.chk) begin
               e = v.e_valid ? v.e_d1 : 32'h0;
               chk("valid", 32'(valid_out), 32'(v.e_valid));
               chk("data1", reg_data1_out, e);
               chk("data2", reg_data2_out, v.e_valid ? ~v.e_d1 : 32'h0);
               chk("imm", sign_ext_offset_out, e << 1);
               chk("pc4", pc_plus4_out, v.e_valid ? v.e_d1 + 32'd4 : 32'h0);
               chk("funct", 32'(funct_out), 32'(e[5:0]));
               chk("shamt", 32'(shamt_out), 32'(e[10:6]));
               chk("alusrc", 32'(alusrc_out), 32'(e[0]));
               chk("regdst", 32'(regdst_out), 32'(e[2:1]));
               chk("aluop", 32'(aluop_out), 32'(e[6:3]));
               chk("memwrite", 32'(memwrite_out), 32'(e[7]));
               chk("memtoreg", 32'(memtoreg_out), 32'(e[8]));
               chk("rs", 32'(rs_out), 32'(v.e_rs));
               chk("rt", 32'(rt_out), 32'(v.e_rt));
               chk("rd", 32'(rd_out), 32'(v.e_rd));
               chk("regwrite", 32'(regwrite_out), 32'(v.e_rw));
               chk("memread", 32'(memread_out), 32'(v.e_mr));
               chk("bubbles", 32'(bubble_count), 32'(v.e_cnt));
            end
         end
      end
   end

   localparam logic [31:0] LD = 32'h1357_0000;
   localparam logic [31:0] DP = 32'h2468_0000;

   initial begin
      logic [3:0] c;
      drive(mk(1,0,0,32'hA5A5_5A5A,3,4,7,1,1,1, 0,0, 0,0,0,0,0,0,0,0));
      drive(mk(1,1,1,32'hDEAD_BEEF,31,31,31,1,1,1, 0,1, 0,0,0,0,0,0,0,0));
      drive(mk(0,0,0,32'h0000_1234,0,0,5,0,1,0, 0,1, 0,0,0,0,0,0,0,0));
      drive(mk(0,0,0,32'h1111_0000,1,8,0,1,1,0, 0,1, 1,32'h0000_1234,0,0,5,1,0,0));
      drive(mk(0,0,0,32'h2222_0000,8,2,10,0,1,1, 1,1, 1,32'h1111_0000,1,8,0,1,1,0));
      drive(mk(0,0,0,32'h2222_0000,8,2,10,0,1,1, 0,1, 0,0,0,0,0,0,0,1));
      drive(mk(0,0,0,32'h3333_0000,2,0,0,1,1,0, 0,1, 1,32'h2222_0000,8,2,10,1,0,1));
      drive(mk(0,0,0,32'h4444_0000,0,0,3,0,1,1, 0,1, 1,32'h3333_0000,2,0,0,1,1,1));
      drive(mk(0,0,0,32'h5555_0000,1,9,0,1,1,0, 0,1, 1,32'h4444_0000,0,0,3,1,0,1));
      drive(mk(0,0,0,32'h6666_0000,2,9,4,0,0,0, 0,1, 1,32'h5555_0000,1,9,0,1,1,1));
      drive(mk(0,0,0,32'h7777_0000,1,9,0,1,1,0, 0,1, 1,32'h6666_0000,2,9,4,0,0,1));
      drive(mk(0,0,0,32'h8888_0000,2,9,4,0,1,1, 1,1, 1,32'h7777_0000,1,9,0,1,1,1));
      drive(mk(0,0,0,32'h9999_0000,1,9,0,1,1,0, 0,1, 0,0,0,0,0,0,0,2));
      drive(mk(0,0,1,32'hAAAA_0000,9,3,4,0,1,0, 0,1, 1,32'h9999_0000,1,9,0,1,1,2));
      drive(mk(0,0,0,32'hBBBB_0000,4,5,6,0,1,1, 0,1, 0,0,0,0,0,0,0,2));
      drive(mk(0,1,1,32'hCCCC_0000,7,7,7,1,1,1, 1,1, 1,32'hBBBB_0000,4,5,6,1,0,2));
      drive(mk(0,1,1,32'hDDDD_0000,7,7,7,1,1,1, 1,1, 1,32'hBBBB_0000,4,5,6,1,0,2));
      drive(mk(0,1,1,32'hEEEE_0000,7,7,7,1,1,1, 1,1, 1,32'hBBBB_0000,4,5,6,1,0,2));
      drive(mk(0,0,1,32'hFFFF_0000,5,5,5,1,1,1, 0,1, 1,32'hBBBB_0000,4,5,6,1,0,2));
      drive(mk(0,0,0,32'h0000_1000,0,0,1,0,1,0, 0,1, 0,0,0,0,0,0,0,2));
      drive(mk(0,0,0,LD,1,9,0,1,1,0, 0,1, 1,32'h0000_1000,0,0,1,1,0,2));
      c = 4'd2;
      for (int i = 0; i < 15; i++) begin
         drive(mk(0,0,0,DP,9,2,3,0,1,0, 1,1, 1,LD,1,9,0,1,1,c));
         c = (c == 4'hF) ? c : c + 4'd1;
         drive(mk(0,0,0,LD,1,9,0,1,1,0, 0,1, 0,0,0,0,0,0,0,c));
      end
      drive(mk(1,0,0,DP,9,2,3,0,1,0, 0,1, 1,LD,1,9,0,1,1,15));
      drive(mk(0,0,0,32'h0000_0ABC,9,9,2,0,1,0, 0,1, 0,0,0,0,0,0,0,0));
      drive(mk(0,0,0,32'h0,0,0,0,0,0,0, 0,1, 1,32'h0000_0ABC,9,9,2,1,0,0));
      repeat (3) @(negedge Clk);
      #1;
      if (q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
